// File: rtl/branch_pc_ctrl.sv
// Fetch-PC sequencer and ID-stage control-transfer resolver for the 5-stage MIPS pipeline.
// Resolves conditional branches, j/jal and jr/jalr in ID, stalls ID until the forwarded
// operands are final, redirects fetch under the if_ready handshake and counts transfers.
// Optional build macro: BRANCH_DELAY_SLOT_EN (MIPS delay slot, no wrong-path squash).
module branch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_ready,
    input  logic             ex_stall,
    input  logic             id_valid,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             id_jr,
    input  logic [3:0]       id_cond,
    input  logic [31:0]      id_pc,
    input  logic [15:0]      id_imm16,
    input  logic [25:0]      id_index26,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             rs_ready,
    input  logic             rt_ready,
    output logic [31:0]      pc_o,
    output logic             fetch_valid,
    output logic             id_stall,
    output logic             flush_ifid,
    output logic             taken,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StWaitOp   = 2'd1,
        StRedirect = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pend_q, pend_d;
    logic [CNT_W-1:0] br_q, br_d;
    logic [CNT_W-1:0] tc_q, tc_d;

    logic        ctl, need_rs, need_rt, ops_ready, cond_true, xfer_taken, apply;
    logic [31:0] seq_pc, target;

    // Operand requirements, condition evaluation and target selection for the ID instruction
    always_comb begin
        ctl     = id_valid & (id_branch | id_jump | id_jr);
        need_rs = ~id_jump & (id_jr | id_branch);
        need_rt = ~id_jump & ~id_jr & id_branch & ((id_cond == 4'b0001) | (id_cond == 4'b0010));
        ops_ready = (~need_rs | rs_ready) & (~need_rt | rt_ready);
        unique case (id_cond)
            4'b0001: cond_true = (rs_val == rt_val);
            4'b0010: cond_true = (rs_val != rt_val);
            4'b0011: cond_true = ($signed(rs_val) <= 32'sd0);
            4'b0100: cond_true = ($signed(rs_val) >  32'sd0);
            4'b0101: cond_true = ($signed(rs_val) >= 32'sd0);
            4'b0110: cond_true = ($signed(rs_val) <  32'sd0);
            default: cond_true = 1'b0;
        endcase
        xfer_taken = id_jump | id_jr | (id_branch & cond_true);
        seq_pc = id_pc + 32'd4;
        if (id_jump) begin
            target = {seq_pc[31:28], id_index26, 2'b00};
        end else if (id_jr) begin
            target = rs_val;
        end else begin
            target = seq_pc + {{14{id_imm16[15]}}, id_imm16, 2'b00};
        end
    end

    // Next-state, PC, counters and per-cycle pulses; ex_stall freezes all of it
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        br_d     = br_q;
        tc_d     = tc_q;
        id_stall = 1'b0;
        taken    = 1'b0;
        apply    = 1'b0;
        unique case (state_q)
            StRun, StWaitOp: begin
                if (ctl && !ops_ready) begin
                    id_stall = 1'b1;
                    if (!ex_stall) state_d = StWaitOp;
                end else if (ex_stall) begin
                    // Hold ID while frozen with an unresolved transfer still waiting
                    id_stall = (state_q == StWaitOp);
                end else if (ctl) begin
                    br_d = br_q + 1'b1;
                    if (xfer_taken) begin
                        taken = 1'b1;
                        tc_d  = tc_q + 1'b1;
                        if (if_ready) begin
                            pc_d    = target;
                            apply   = 1'b1;
                            state_d = StRun;
                        end else begin
                            pend_d  = target;
                            state_d = StRedirect;
                        end
                    end else begin
                        if (if_ready) pc_d = pc_q + 32'd4;
                        state_d = StRun;
                    end
                end else begin
                    if (if_ready) pc_d = pc_q + 32'd4;
                    state_d = StRun;
                end
            end
            StRedirect: begin
                if (!ex_stall && if_ready) begin
                    pc_d    = pend_q;
                    apply   = 1'b1;
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
            br_q    <= '0;
            tc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            br_q    <= br_d;
            tc_q    <= tc_d;
        end
    end

    // Output mapping; the delay-slot build lets the id_pc+4 instruction complete
    always_comb begin
        pc_o        = pc_q;
        fetch_valid = ~rst;
        br_count    = br_q;
        taken_count = tc_q;
`ifdef BRANCH_DELAY_SLOT_EN
        flush_ifid  = 1'b0;
`else
        flush_ifid  = apply;
`endif
    end

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Directed self-checking bench for branch_pc_ctrl.
module tb_branch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst, if_ready, ex_stall, id_valid, id_branch, id_jump, id_jr;
    logic [3:0]  id_cond;
    logic [31:0] id_pc, rs_val, rt_val;
    logic [15:0] id_imm16;
    logic [25:0] id_index26;
    logic        rs_ready, rt_ready;
    logic [31:0] pc_o;
    logic        fetch_valid, id_stall, flush_ifid, taken;
    logic [31:0] br_count, taken_count;

    int checks = 0;
    int failures = 0;
    logic exp_flush;

    branch_pc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .if_ready   (if_ready),
        .ex_stall   (ex_stall),
        .id_valid   (id_valid),
        .id_branch  (id_branch),
        .id_jump    (id_jump),
        .id_jr      (id_jr),
        .id_cond    (id_cond),
        .id_pc      (id_pc),
        .id_imm16   (id_imm16),
        .id_index26 (id_index26),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .rs_ready   (rs_ready),
        .rt_ready   (rt_ready),
        .pc_o       (pc_o),
        .fetch_valid(fetch_valid),
        .id_stall   (id_stall),
        .flush_ifid (flush_ifid),
        .taken      (taken),
        .br_count   (br_count),
        .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_branch = 0; id_jump = 0; id_jr = 0; id_cond = 4'd0;
    endtask

    initial begin
`ifdef BRANCH_DELAY_SLOT_EN
        exp_flush = 1'b0;
`else
        exp_flush = 1'b1;
`endif
        rst = 1; if_ready = 0; ex_stall = 0; clear_id();
        id_pc = 0; id_imm16 = 0; id_index26 = 0; rs_val = 0; rt_val = 0;
        rs_ready = 0; rt_ready = 0;
        step(); step();
        chk("rst_pc", pc_o, 32'h3000);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rst_stall", {31'd0, id_stall}, 32'd0);
        chk("rst_taken", {31'd0, taken}, 32'd0);
        chk("rst_br", br_count, 32'd0);
        chk("rst_tc", taken_count, 32'd0);

        // Sequential fetch
        rst = 0; if_ready = 1; #1;
        chk("seq_pc0", pc_o, 32'h3000);
        chk("seq_fv", {31'd0, fetch_valid}, 32'd1);
        step(); chk("seq_pc1", pc_o, 32'h3004);
        step(); chk("seq_pc2", pc_o, 32'h3008);
        chk("seq_br", br_count, 32'd0);

        // Taken beq: 0x3010 + 4 - 8 = 0x300C
        id_valid = 1; id_branch = 1; id_cond = 4'b0001; id_pc = 32'h3010; id_imm16 = 16'hFFFE;
        rs_val = 5; rt_val = 5; rs_ready = 1; rt_ready = 1; #1;
        chk("beq_taken", {31'd0, taken}, 32'd1);
        chk("beq_flush", {31'd0, flush_ifid}, {31'd0, exp_flush});
        chk("beq_stall", {31'd0, id_stall}, 32'd0);
        step(); clear_id(); #1;
        chk("beq_pc", pc_o, 32'h300C);
        chk("beq_br", br_count, 32'd1);
        chk("beq_tc", taken_count, 32'd1);
        chk("beq_pulse_end", {31'd0, taken}, 32'd0);
        chk("beq_flush_end", {31'd0, flush_ifid}, 32'd0);

        // bgtz waiting on rs: target 0x3104 + 0x40 = 0x3144
        id_valid = 1; id_branch = 1; id_cond = 4'b0100; id_pc = 32'h3100; id_imm16 = 16'h0010;
        rs_val = 1; rs_ready = 0; rt_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wait_stall", {31'd0, id_stall}, 32'd1);
            chk("wait_taken", {31'd0, taken}, 32'd0);
            chk("wait_pc", pc_o, 32'h300C);
            step();
        end
        rs_ready = 1; #1;
        chk("wait_res_stall", {31'd0, id_stall}, 32'd0);
        chk("wait_res_taken", {31'd0, taken}, 32'd1);
        step(); clear_id(); #1;
        chk("wait_pc_tgt", pc_o, 32'h3144);
        chk("wait_br", br_count, 32'd2);
        chk("wait_tc", taken_count, 32'd2);

        // jr with imem not ready: redirect held until if_ready
        if_ready = 0; id_valid = 1; id_jr = 1; rs_val = 32'h4000; rs_ready = 1; #1;
        chk("jr_taken", {31'd0, taken}, 32'd1);
        chk("jr_noflush", {31'd0, flush_ifid}, 32'd0);
        step(); clear_id(); #1;
        chk("jr_hold0", pc_o, 32'h3144);
        chk("jr_pulse_end", {31'd0, taken}, 32'd0);
        chk("jr_nostall", {31'd0, id_stall}, 32'd0);
        step();
        chk("jr_hold1", pc_o, 32'h3144);
        if_ready = 1; #1;
        chk("jr_apply_flush", {31'd0, flush_ifid}, {31'd0, exp_flush});
        step();
        chk("jr_pc", pc_o, 32'h4000);
        chk("jr_br", br_count, 32'd3);
        chk("jr_tc", taken_count, 32'd3);

        // bne under ex_stall: target 0x4004 + 0x10 = 0x4014
        ex_stall = 1; id_valid = 1; id_branch = 1; id_cond = 4'b0010; id_pc = 32'h4000;
        id_imm16 = 16'h0004; rs_val = 1; rt_val = 2; rs_ready = 1; rt_ready = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("exs_taken", {31'd0, taken}, 32'd0);
            chk("exs_flush", {31'd0, flush_ifid}, 32'd0);
            step();
            chk("exs_pc", pc_o, 32'h4000);
            chk("exs_br", br_count, 32'd3);
        end
        ex_stall = 0; #1;
        chk("exs_res_taken", {31'd0, taken}, 32'd1);
        step(); clear_id(); #1;
        chk("exs_pc_tgt", pc_o, 32'h4014);
        chk("exs_br_after", br_count, 32'd4);
        chk("exs_tc_after", taken_count, 32'd4);

        // Undefined condition code: not taken but counted
        id_valid = 1; id_branch = 1; id_cond = 4'b1111; id_pc = 32'h4010; id_imm16 = 16'h0100; #1;
        chk("undef_taken", {31'd0, taken}, 32'd0);
        step(); clear_id(); #1;
        chk("undef_pc", pc_o, 32'h4018);
        chk("undef_br", br_count, 32'd5);
        chk("undef_tc", taken_count, 32'd4);

        // j while imem stalled enters REDIRECT, then reset aborts it
        if_ready = 0; id_valid = 1; id_jump = 1; id_pc = 32'h4018; id_index26 = 26'h0000100; #1;
        chk("j_taken", {31'd0, taken}, 32'd1);
        step(); clear_id();
        chk("j_tc", taken_count, 32'd5);
        rst = 1; step();
        chk("rr_pc", pc_o, 32'h3000);
        chk("rr_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rr_br", br_count, 32'd0);
        chk("rr_tc", taken_count, 32'd0);
        rst = 0; if_ready = 1; #1;
        chk("rr_noflush", {31'd0, flush_ifid}, 32'd0);
        step();
        chk("rr_run_pc", pc_o, 32'h3004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_pc_ctrl.md
Name: branch_pc_ctrl

Overview:
- Fetch-PC sequencer and control-transfer resolver for the 5-stage MIPS pipeline.
- Resolves branches, j/jal and jr in ID, and stalls ID until forwarded operands are ready.
- Redirects the fetch PC under a fetch-accept handshake and squashes the wrong-path fetch.
- Keeps 32-bit branch statistics counters.

Parameters:
- RESET_PC, 32'h0000_3000: fetch address loaded on reset.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- if_ready  in  1  imem accepts the current fetch this cycle.
- ex_stall  in  1  downstream stall; freezes this block entirely.
- id_valid  in  1  ID holds a valid instruction.
- id_branch  in  1  ID instruction is a conditional branch.
- id_jump  in  1  ID instruction is j/jal.
- id_jr  in  1  ID instruction is jr/jalr.
- id_cond  in  4  branch condition code.
- id_pc  in  32  PC of the ID instruction.
- id_imm16  in  16  branch offset.
- id_index26  in  26  jump index.
- rs_val  in  32  forwarded rs value.
- rt_val  in  32  forwarded rt value.
- rs_ready  in  1  rs_val is final.
- rt_ready  in  1  rt_val is final.
- pc_o  out  32  fetch address.
- fetch_valid  out  1  fetch request valid.
- id_stall  out  1  hold the IF/ID register and the ID stage.
- flush_ifid  out  1  discard the instruction captured into IF/ID this edge.
- taken  out  1  one-cycle pulse: control transfer taken.
- br_count  out  CNT_W  resolved control transfers.
- taken_count  out  CNT_W  taken control transfers.

Behaviour:
- Reset values: pc_o=RESET_PC, fetch_valid=0 during rst and 1 from the first cycle after, id_stall=0, flush_ifid=0, taken=0, counters=0, state=RUN, pending target=0. A reset mid-operation (any state) aborts everything to these values.
- Fetch handshake:
  - pc_o must stay stable while fetch_valid=1 and if_ready=0.
  - In RUN, pc_o<=pc_o+4 when if_ready=1, id_stall=0 and ex_stall=0.
- Condition codes, signed compares:
  - 0001: rs==rt
  - 0010: rs!=rt
  - 0011: rs<=0
  - 0100: rs>0
  - 0101: rs>=0
  - 0110: rs<0
  - Any other code: not taken, still counted in br_count.
- Targets, modulo 2^32:
  - Branch: id_pc+4+(sext(id_imm16)<<2).
  - j: {id_pc+4[31:28], id_index26, 2'b00}.
  - jr: rs_val.
  - j and jr are always taken.
- Operands needed:
  - Branch with code 0001/0010: rs and rt.
  - Other branches and jr: rs.
  - j: none.
- Priority: rst > ex_stall > resolution. While ex_stall=1: no state, PC or counter change; taken=0; flush_ifid=0.
- States:
  - RUN:
    - id_valid and a control transfer with any needed operand not ready: id_stall=1, go to WAIT_OP.
    - Operands ready: resolve combinationally this cycle, increment br_count.
    - Taken with if_ready=1: pc_o<=target, taken=1, taken_count++, flush_ifid=1 (see feature).
    - Taken with if_ready=0: taken=1, taken_count++, latch target into the pending register, go to REDIRECT.
    - Not taken: normal sequential fetch.
  - WAIT_OP:
    - id_stall=1 and pc_o held until operands are ready.
    - Then resolve exactly as in RUN. id_stall drops in the resolving cycle; next state is RUN or REDIRECT.
    - Each control transfer is counted once only.
  - REDIRECT:
    - id_stall=0.
    - On if_ready=1: pc_o<=pending target, flush_ifid=1 (see feature), go to RUN.
    - Control transfers arriving in ID while in this state are not resolved until RUN.
- taken and flush_ifid are combinational for the resolving/applying cycle only, never held.
- Counters wrap from all-ones to 0.

Optional Feature:
- BRANCH_DELAY_SLOT_EN defined: MIPS delay slot. flush_ifid is tied 0; the instruction at id_pc+4 completes; the target is fetched next.
- Undefined: flush_ifid asserts in the cycle the redirect is applied, squashing the wrong-path instruction at id_pc+4.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles, then if_ready=1 with no branches.
  - Required: pc_o = 0x3000, 0x3004, 0x3008; counters 0.
- Taken beq:
  - Stimulus: id_pc=0x3010, imm=0xFFFE, rs=rt=5, readies 1, if_ready=1.
  - Required: next pc_o=0x300C; taken=1 for one cycle; flush_ifid=1 (macro off) or 0 (macro on); br_count=1, taken_count=1.
- Operand wait:
  - Stimulus: bgtz with rs_ready=0 for 3 cycles, rs=1.
  - Required: id_stall=1 for 3 cycles and pc_o frozen; on the 4th cycle taken=1; br_count increments by exactly 1.
- Redirect handshake:
  - Stimulus: jr with rs=0x4000 while if_ready=0 for 2 cycles.
  - Required: pc_o unchanged until if_ready=1; then pc_o=0x4000.
- ex_stall precedence:
  - Stimulus: taken bne with ex_stall=1 for 2 cycles.
  - Required: no taken pulse and no counter change during the stall; resolution occurs in the first cycle after ex_stall=0.
- Edge cases:
  - Stimulus: id_cond=4'b1111 branch; separately, reset asserted while in REDIRECT.
  - Required: undefined code gives taken=0 with br_count++; reset gives state RUN and pc_o=0x3000.
